uart_rx_ctrl: RTL and testbench

UART receive controller that sequences the receive shift register. It oversamples the serial line and finds the start bit. It samples each data bit at mid-bit, issues one-cycle shift strobes with the sampled bit to the external serial-to-parallel register, checks the stop bit, and reports frame completion. It sits between the baud-rate generator and the receive datapath.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default frame
// geometry used as parameter defaults by the receive controller.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line plus a falling-edge
// detector on the synchronized value. All flops reset high (idle line) so
// leaving reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_rxd,
  output logic o_rxd_s,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the line and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rxd_s = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer. Finds the start bit on the oversampled line,
// samples each data bit at mid-bit and strobes it into the external
// shift register, then checks the stop bit and reports frame completion.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after
// the data bits and the o_parity_err output.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line (needs arm)
// START  | counting to mid start bit to reject glitches
// DATA   | sampling DATA_BITS data bits, one shift strobe each
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then rx_done
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic i_baud_tick,
  input  logic i_rxd,
  output logic o_shift,
  output logic o_rx_bit,
  output logic o_rx_done,
  output logic o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic o_parity_err,
`endif
  output logic o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

  logic w_rxd_s;
  logic w_fall;

  rx_state_e       r_state;
  logic [TW-1:0]   r_tcnt;
  logic [BW-1:0]   r_bcnt;
  logic            r_arm;
`ifdef UART_RX_PARITY_EN
  logic            r_par;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_rxd   (i_rxd),
    .o_rxd_s (w_rxd_s),
    .o_fall  (w_fall)
  );

  // Frame sequencer; every output is registered here and the strobes
  // default low so they last exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_arm       <= 1'b1;
      o_shift     <= 1'b0;
      o_rx_bit    <= 1'b1;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_shift   <= 1'b0;
      o_rx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A break leaves the receiver disarmed until the line returns high.
          if (w_rxd_s) r_arm <= 1'b1;
          if (w_fall && r_arm) begin
            r_state <= START;
            r_tcnt  <= '0;
            o_busy  <= 1'b1;
          end
        end
        START: begin
          if (i_baud_tick) begin
            if (r_tcnt == TC_HALF) begin
              r_tcnt <= '0;
              if (!w_rxd_s) begin
                r_state <= DATA;
                r_bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                r_par   <= 1'b0;
`endif
              end else begin
                r_state <= IDLE;
                o_busy  <= 1'b0;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_baud_tick) begin
            if (r_tcnt == TC_FULL) begin
              r_tcnt   <= '0;
              o_shift  <= 1'b1;
              o_rx_bit <= w_rxd_s;
              r_bcnt   <= r_bcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
              r_par    <= r_par ^ w_rxd_s;
              if (r_bcnt == BC_LAST) r_state <= PARITY;
`else
              if (r_bcnt == BC_LAST) r_state <= STOP;
`endif
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_baud_tick) begin
            if (r_tcnt == TC_FULL) begin
              r_tcnt  <= '0;
              r_par   <= r_par ^ w_rxd_s;
              r_state <= STOP;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (i_baud_tick) begin
            if (r_tcnt == TC_FULL) begin
              r_tcnt      <= '0;
              o_rx_done   <= 1'b1;
              o_frame_err <= ~w_rxd_s;
              r_arm       <= w_rxd_s;
              r_state     <= IDLE;
              o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
              o_parity_err <= r_par;
`endif
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: drives serial frames on a tick
// grid and compares the shift strobes and rx_done reports against the
// frame contents the bench itself transmitted.
module tb_uart_rx_ctrl;

  localparam int OS   = 16;
  localparam int DB   = 8;
  localparam int TDIV = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int DONE_TICKS = (DB + 1 + PB) * OS + OS / 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic baud_tick = 1'b0;
  logic rxd = 1'b1;
  logic shift, rx_bit, rx_done, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  int total = 0;
  int bad = 0;
  int g_ticks = 0;
  int n_both = 0;

  logic q_bits[$];
  logic q_fe[$];
  logic q_pe[$];
  int   q_dt[$];

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_baud_tick (baud_tick),
    .i_rxd       (rxd),
    .o_shift     (shift),
    .o_rx_bit    (rx_bit),
    .o_rx_done   (rx_done),
    .o_frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(parity_err),
`endif
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TDIV - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always @(posedge clk) if (baud_tick) g_ticks <= g_ticks + 1;

  always @(negedge clk) begin
    if (shift) q_bits.push_back(rx_bit);
    if (rx_done) begin
      q_fe.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
      q_pe.push_back(parity_err);
`else
      q_pe.push_back(1'b0);
`endif
      q_dt.push_back(g_ticks);
    end
    if (shift && rx_done) n_both++;
  end

  task automatic mon_clear();
    q_bits.delete(); q_fe.delete(); q_pe.delete(); q_dt.delete();
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic align();
    wait_ticks(1);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    wait_ticks(OS);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit, output int t0);
    t0 = g_ticks;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PB == 1) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (shift !== 1'b0) begin bad++; $display("FAIL reset_shift: got %b want 0", shift); end
    total++; if (rx_bit !== 1'b1) begin bad++; $display("FAIL reset_rx_bit: got %b want 1", rx_bit); end
    total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef UART_RX_PARITY_EN
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
`endif
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_a5();
    int t0;
    logic [7:0] d;
    d = 8'hA5;
    mon_clear();
    align();
    send_frame(d, 1'b1, 1'b0, t0);
    rxd = 1'b1;
    wait_ticks(OS);
    total++; if (q_bits.size() != DB) begin bad++; $display("FAIL a5_shift_count: got %0d want %0d", q_bits.size(), DB); end
    for (int i = 0; i < DB && i < q_bits.size(); i++) begin
      total++;
      if (q_bits[i] !== d[i]) begin bad++; $display("FAIL a5_bit%0d: got %b want %b", i, q_bits[i], d[i]); end
    end
    total++; if (q_fe.size() != 1) begin bad++; $display("FAIL a5_done_count: got %0d want 1", q_fe.size()); end
    if (q_fe.size() >= 1) begin
      total++; if (q_fe[0] !== 1'b0) begin bad++; $display("FAIL a5_frame_err: got %b want 0", q_fe[0]); end
      total++; if (q_dt[0] - t0 != DONE_TICKS) begin bad++; $display("FAIL a5_done_latency: got %0d ticks want %0d", q_dt[0] - t0, DONE_TICKS); end
    end
  endtask

  task automatic test_random_frames();
    logic exp_bits[$];
    logic exp_fe[$];
    logic [7:0] d;
    logic stop;
    int t0;
    mon_clear();
    align();
    for (int f = 0; f < 6; f++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < DB; i++) exp_bits.push_back(d[i]);
      exp_fe.push_back(!stop);
      send_frame(d, stop, ^d, t0);
      rxd = 1'b1;
      wait_ticks(OS);
      #1;
    end
    total++; if (q_bits.size() != exp_bits.size()) begin bad++; $display("FAIL rnd_shift_count: got %0d want %0d", q_bits.size(), exp_bits.size()); end
    for (int i = 0; i < exp_bits.size() && i < q_bits.size(); i++) begin
      total++;
      if (q_bits[i] !== exp_bits[i]) begin bad++; $display("FAIL rnd_bit%0d: got %b want %b", i, q_bits[i], exp_bits[i]); end
    end
    total++; if (q_fe.size() != exp_fe.size()) begin bad++; $display("FAIL rnd_done_count: got %0d want %0d", q_fe.size(), exp_fe.size()); end
    for (int i = 0; i < exp_fe.size() && i < q_fe.size(); i++) begin
      total++;
      if (q_fe[i] !== exp_fe[i]) begin bad++; $display("FAIL rnd_frame_err%0d: got %b want %b", i, q_fe[i], exp_fe[i]); end
    end
  endtask

  task automatic test_false_start();
    mon_clear();
    align();
    rxd = 1'b0;
    wait_ticks(4);
    #1;
    rxd = 1'b1;
    wait_ticks(1);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fs_busy_during: got %b want 1", busy); end
    wait_ticks(OS / 2);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fs_busy_after: got %b want 0", busy); end
    wait_ticks(2 * OS);
    total++; if (q_bits.size() != 0) begin bad++; $display("FAIL fs_shift_count: got %0d want 0", q_bits.size()); end
    total++; if (q_fe.size() != 0) begin bad++; $display("FAIL fs_done_count: got %0d want 0", q_fe.size()); end
  endtask

  task automatic test_break();
    logic [7:0] d;
    logic [7:0] got;
    int t0;
    d = 8'h3C;
    mon_clear();
    align();
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PB == 1) drive_bit(^d);
    rxd = 1'b0;
    wait_ticks(3 * OS);
    #1;
    rxd = 1'b1;
    wait_ticks(2 * OS);
    #1;
    got = '0;
    for (int i = 0; i < DB && i < q_bits.size(); i++) got[i] = q_bits[i];
    total++; if (q_bits.size() != DB) begin bad++; $display("FAIL brk_shift_count: got %0d want %0d", q_bits.size(), DB); end
    total++; if (got !== d) begin bad++; $display("FAIL brk_data: got %h want %h", got, d); end
    total++; if (q_fe.size() != 1) begin bad++; $display("FAIL brk_done_count: got %0d want 1", q_fe.size()); end
    if (q_fe.size() >= 1) begin
      total++; if (q_fe[0] !== 1'b1) begin bad++; $display("FAIL brk_frame_err: got %b want 1", q_fe[0]); end
    end
    mon_clear();
    d = 8'($urandom_range(0, 255));
    send_frame(d, 1'b1, ^d, t0);
    rxd = 1'b1;
    wait_ticks(OS);
    got = '0;
    for (int i = 0; i < DB && i < q_bits.size(); i++) got[i] = q_bits[i];
    total++; if (got !== d || q_bits.size() != DB) begin bad++; $display("FAIL brk_recover_data: got %h (%0d bits) want %h", got, q_bits.size(), d); end
    total++; if (q_fe.size() != 1 || (q_fe.size() == 1 && q_fe[0] !== 1'b0)) begin bad++; $display("FAIL brk_recover_done: got %0d dones want 1 clean", q_fe.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic [7:0] got;
    int t0;
    d = 8'hF3;
    mon_clear();
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    total++; if (q_bits.size() != 3) begin bad++; $display("FAIL rst_pre_shifts: got %0d want 3", q_bits.size()); end
    @(negedge clk);
    reset = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (rx_bit !== 1'b1) begin bad++; $display("FAIL rst_rx_bit: got %b want 1", rx_bit); end
    total++; if (shift !== 1'b0 || rx_done !== 1'b0) begin bad++; $display("FAIL rst_strobes: got %b%b want 00", shift, rx_done); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ticks(2 * OS);
    total++; if (q_fe.size() != 0) begin bad++; $display("FAIL rst_no_done: got %0d want 0", q_fe.size()); end
    mon_clear();
    align();
    d = 8'h5A;
    send_frame(d, 1'b1, ^d, t0);
    rxd = 1'b1;
    wait_ticks(OS);
    got = '0;
    for (int i = 0; i < DB && i < q_bits.size(); i++) got[i] = q_bits[i];
    total++; if (q_bits.size() != DB) begin bad++; $display("FAIL rst_5a_shifts: got %0d want %0d", q_bits.size(), DB); end
    total++; if (got !== d) begin bad++; $display("FAIL rst_5a_data: got %h want %h", got, d); end
    total++; if (q_fe.size() != 1 || (q_fe.size() == 1 && q_fe[0] !== 1'b0)) begin bad++; $display("FAIL rst_5a_done: got %0d dones want 1 clean", q_fe.size()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    logic [15:0] exp;
    int t0, t1;
    mon_clear();
    align();
    send_frame(8'hFF, 1'b1, 1'b0, t0);
    send_frame(8'h00, 1'b1, 1'b0, t1);
    rxd = 1'b1;
    wait_ticks(OS);
    exp = 16'h00FF;
    got = '0;
    for (int i = 0; i < 16 && i < q_bits.size(); i++) got[i] = q_bits[i];
    total++; if (q_bits.size() != 2 * DB) begin bad++; $display("FAIL b2b_shift_count: got %0d want %0d", q_bits.size(), 2 * DB); end
    total++; if (got !== exp) begin bad++; $display("FAIL b2b_data: got %h want %h", got, exp); end
    total++; if (q_fe.size() != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", q_fe.size()); end
    if (q_fe.size() == 2) begin
      total++; if (q_fe[0] !== 1'b0 || q_fe[1] !== 1'b0) begin bad++; $display("FAIL b2b_frame_err: got %b%b want 00", q_fe[0], q_fe[1]); end
      total++; if (q_dt[1] - t1 != DONE_TICKS) begin bad++; $display("FAIL b2b_latency2: got %0d want %0d", q_dt[1] - t1, DONE_TICKS); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    logic pbit;
    int t0;
    mon_clear();
    align();
    for (int k = 0; k < 4; k++) begin
      d = (k < 2) ? 8'hA5 : 8'($urandom_range(0, 255));
      pbit = k[0];
      send_frame(d, 1'b1, pbit, t0);
      rxd = 1'b1;
      wait_ticks(OS);
      #1;
      total++;
      if (q_pe.size() != k + 1) begin bad++; $display("FAIL par_done_count%0d: got %0d want %0d", k, q_pe.size(), k + 1); end
      else if (q_pe[k] !== ((^d) ^ pbit)) begin bad++; $display("FAIL par_err%0d: got %b want %b", k, q_pe[k], (^d) ^ pbit); end
    end
  endtask
`endif

  task automatic test_exclusive();
    total++; if (n_both != 0) begin bad++; $display("FAIL shift_done_overlap: got %0d cycles want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_random_frames();
    test_false_start();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
